zl_reset_sequencer: RTL and testbench

ZL_RESET_SEQUENCER -- requirements
Module: zl_reset_sequencer

---
 rtl/zl_reset_seq_pkg.sv | 15 +
 rtl/zl_reset_seq_timer.sv | 34 +++
 rtl/zl_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_zl_reset_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zl_reset_seq_pkg.sv
// Shared constants for the reset sequencer: FSM encodings and counter sizing.
package zl_reset_seq_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Smallest width able to hold max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/zl_reset_seq_timer.sv
// Saturating up-counter with synchronous clear/load and terminal-count flag.
module zl_reset_seq_timer #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] cnt;

  // Clear beats load beats count; the count holds once it reaches TERM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != TERM_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM_V);

endmodule

// File: rtl/zl_reset_sequencer.sv
// Ordered reset release: waits for PLL lock, holds, then releases stages in turn.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   ST_WAIT_LOCK | all stages in reset, waiting for pll_locked
//   ST_HOLD      | lock seen, counting HOLD_CYCLES of stable lock
//   ST_RELEASE   | releasing stages one every STAGE_GAP cycles
//   ST_RUN       | all stages released
module zl_reset_sequencer
  import zl_reset_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                sw_rst_req,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                done,
  output logic                busy
);

  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int GW = cnt_width(STAGE_GAP);

  logic [1:0]          state, state_nxt;
  logic [N_STAGES-1:0] stage_shift, stage_nxt;
  logic                abort, rel, last;
  logic                hold_tc, gap_tc;
  logic                hold_clr, hold_en, gap_clr, gap_en;

  assign abort = !pll_locked || sw_rst_req;

  // Next thermometer value: one more stage released.
  always_comb begin
    stage_shift    = stage_rst_n << 1;
    stage_shift[0] = 1'b1;
  end

  assign last = &stage_shift;

  // Next-state logic; aborts take precedence over any pending release.
  always_comb begin
    state_nxt = state;
    rel       = 1'b0;
    case (state)
      ST_WAIT_LOCK: begin
        if (pll_locked) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (hold_tc) begin
          rel       = 1'b1;
          state_nxt = last ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (abort) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (gap_tc) begin
          rel       = 1'b1;
          state_nxt = last ? ST_RUN : ST_RELEASE;
        end
      end
      ST_RUN: begin
        if (abort) state_nxt = ST_WAIT_LOCK;
      end
      default: state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Stage vector only grows by one bit per release and collapses on abort.
  always_comb begin
    if (state_nxt == ST_WAIT_LOCK) stage_nxt = '0;
    else if (rel)                  stage_nxt = stage_shift;
    else                           stage_nxt = stage_rst_n;
  end

  assign hold_clr = (state != ST_HOLD) || (state_nxt != ST_HOLD);
  assign hold_en  = (state == ST_HOLD) && pll_locked;
  assign gap_clr  = (state_nxt != ST_RELEASE);
  assign gap_en   = (state == ST_RELEASE);

  zl_reset_seq_timer #(.W(HW), .TERM(HOLD_CYCLES)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hold_clr),
    .load     (1'b0),
    .load_val ({HW{1'b0}}),
    .en       (hold_en),
    .tc       (hold_tc)
  );

  // Loading 1 on each release makes the next release land STAGE_GAP edges later.
  zl_reset_seq_timer #(.W(GW), .TERM(STAGE_GAP)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gap_clr),
    .load     (rel),
    .load_val (GW'(1)),
    .en       (gap_en),
    .tc       (gap_tc)
  );

  // State and all outputs registered from next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_WAIT_LOCK;
      stage_rst_n <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      stage_rst_n <= stage_nxt;
      done        <= (state_nxt == ST_RUN);
      busy        <= (state_nxt == ST_HOLD) || (state_nxt == ST_RELEASE);
    end
  end

endmodule

// File: tb/tb_zl_reset_sequencer.sv
// Self-checking bench for zl_reset_sequencer: default build plus a 1-stage build.
module tb_zl_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, pll_locked, sw_rst_req;
  logic [2:0] st0;
  logic       done0, busy0;
  logic       rst1, lock1, sw1;
  logic [0:0] st1;
  logic       done1, busy1;

  typedef struct {
    int         cyc;
    logic [2:0] stage;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zl_reset_sequencer dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sw_rst_req  (sw_rst_req),
    .stage_rst_n (st0),
    .done        (done0),
    .busy        (busy0)
  );

  zl_reset_sequencer #(.N_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(4)) dut1 (
    .clk         (clk),
    .rst_n       (rst1),
    .pll_locked  (lock1),
    .sw_rst_req  (sw1),
    .stage_rst_n (st1),
    .done        (done1),
    .busy        (busy1)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_exp(input int c, input logic [2:0] s, input logic d, input logic b);
    exp_t x;
    x.cyc = c; x.stage = s; x.done = d; x.busy = b;
    sb.push_back(x);
  endtask

  // Pushes the full nominal release schedule relative to the lock-sample edge e0.
  task automatic push_nominal(input int e0);
    push_exp(e0,      3'b000, 1'b0, 1'b1);
    push_exp(e0 + 16, 3'b000, 1'b0, 1'b1);
    push_exp(e0 + 17, 3'b001, 1'b0, 1'b1);
    push_exp(e0 + 20, 3'b001, 1'b0, 1'b1);
    push_exp(e0 + 21, 3'b011, 1'b0, 1'b1);
    push_exp(e0 + 24, 3'b011, 1'b0, 1'b1);
    push_exp(e0 + 25, 3'b111, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b1;
    rst1 = 1'b0; lock1 = 1'b1; sw1 = 1'b0;
    push_exp(cyc + 1, 3'b000, 1'b0, 1'b0);
    push_exp(cyc + 2, 3'b000, 1'b0, 1'b0);
    repeat (2) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL reset cyc %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if ({st1, done1, busy1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_n1: stage=%b done=%b busy=%b, expected 0 0 0", st1, done1, busy1);
    end
  endtask

  // Lock already high when rst_n releases: HOLD starts on the first edge.
  task automatic test_nominal();
    int e0;
    sw_rst_req = 1'b0; rst_n = 1'b1;
    e0 = cyc + 1;
    push_nominal(e0);
    repeat (26) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL nominal edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL nominal_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_sw_run();
    int e0;
    sw_rst_req = 1'b1;
    push_exp(cyc + 1, 3'b000, 1'b0, 1'b0);
    e0 = cyc + 2;
    push_nominal(e0);
    for (int k = 0; k < 27; k++) begin
      tick();
      sw_rst_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL sw_run edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sw_run_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_lock_glitch();
    int e0, e1;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    e0 = cyc + 1;
    e1 = e0 + 11;
    push_exp(e0,      3'b000, 1'b0, 1'b1);
    push_exp(e0 + 10, 3'b000, 1'b0, 1'b0);
    push_exp(e1,      3'b000, 1'b0, 1'b1);
    push_exp(e1 + 6,  3'b000, 1'b0, 1'b1);
    push_exp(e1 + 16, 3'b000, 1'b0, 1'b1);
    push_exp(e1 + 17, 3'b001, 1'b0, 1'b1);
    for (int k = 0; k < 29; k++) begin
      tick();
      if (cyc == e0 + 9)  pll_locked = 1'b0;
      if (cyc == e0 + 10) pll_locked = 1'b1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL lock_glitch edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL lock_glitch_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  // A software request while waiting for lock must not block the start.
  task automatic test_sw_wait();
    int e0;
    pll_locked = 1'b0;
    repeat (2) tick();
    sw_rst_req = 1'b1;
    pll_locked = 1'b1;
    e0 = cyc + 1;
    push_exp(e0,      3'b000, 1'b0, 1'b1);
    push_exp(e0 + 17, 3'b001, 1'b0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      tick();
      sw_rst_req = 1'b0;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL sw_wait edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sw_wait_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_rst_mid();
    int e0, e1;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    e0 = cyc + 1;
    e1 = e0 + 21;
    push_exp(e0 + 17, 3'b001, 1'b0, 1'b1);
    push_exp(e0 + 19, 3'b001, 1'b0, 1'b1);
    push_exp(e0 + 20, 3'b000, 1'b0, 1'b0);
    push_exp(e1,      3'b000, 1'b0, 1'b1);
    push_exp(e1 + 17, 3'b001, 1'b0, 1'b1);
    for (int k = 0; k < 39; k++) begin
      tick();
      if (cyc == e0 + 19) rst_n = 1'b0;
      if (cyc == e0 + 20) rst_n = 1'b1;
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL rst_mid edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rst_mid_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_double_abort();
    int e0, e1;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    e0 = cyc + 1;
    e1 = e0 + 23;
    push_exp(e0 + 21, 3'b011, 1'b0, 1'b1);
    push_exp(e0 + 22, 3'b000, 1'b0, 1'b0);
    push_nominal(e1);
    for (int k = 0; k < 49; k++) begin
      tick();
      if (cyc == e0 + 21) begin pll_locked = 1'b0; sw_rst_req = 1'b1; end
      if (cyc == e0 + 22) begin pll_locked = 1'b1; sw_rst_req = 1'b0; end
      checks++;
      if (!(st0 == 3'b000 || st0 == 3'b001 || st0 == 3'b011 || st0 == 3'b111)) begin
        errors++;
        $display("FAIL thermometer edge %0d: stage=%b, expected thermometer code", cyc - e0, st0);
      end
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || st0 !== e.stage || done0 !== e.done || busy0 !== e.busy) begin
          errors++;
          $display("FAIL double_abort edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st0, done0, busy0, e.stage, e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL double_abort_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_single_stage();
    int e0;
    rst1 = 1'b1; lock1 = 1'b0; sw1 = 1'b0;
    tick();
    lock1 = 1'b1;
    e0 = cyc + 1;
    push_exp(e0,     3'b000, 1'b0, 1'b1);
    push_exp(e0 + 1, 3'b000, 1'b0, 1'b1);
    push_exp(e0 + 2, 3'b001, 1'b1, 1'b0);
    push_exp(e0 + 3, 3'b001, 1'b1, 1'b0);
    push_exp(e0 + 4, 3'b000, 1'b0, 1'b0);
    push_exp(e0 + 5, 3'b000, 1'b0, 1'b1);
    push_exp(e0 + 7, 3'b001, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      sw1 = (cyc == e0 + 3);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); checks++;
        if (e.cyc != cyc || {2'b00, st1} !== e.stage || done1 !== e.done || busy1 !== e.busy) begin
          errors++;
          $display("FAIL single_stage edge %0d: stage=%b done=%b busy=%b, expected stage=%b done=%b busy=%b",
                   e.cyc - e0, st1, done1, busy1, e.stage[0], e.done, e.busy);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL single_stage_pending: %0d left, expected 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; sw_rst_req = 1'b0;
    rst1 = 1'b0; lock1 = 1'b0; sw1 = 1'b0;
    test_reset();
    test_nominal();
    test_sw_run();
    test_lock_glitch();
    test_sw_wait();
    test_rst_mid();
    test_double_abort();
    test_single_stage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
